// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer: default word width, the
// packer state encoding and the count-width helper.
package fifo_pkg;

  localparam int WL_DEF = 5;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Bits needed to count 0..pack inclusive.
  function automatic int cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_pack_lanes.sv
// Lane register array for the word packer. One word is written per cycle
// at the capture index. A clear zeroes every lane, so the lanes of a partial
// beat that were never written read back as 0.
module fifo_pack_lanes #(
  parameter int WL   = 5,
  parameter int PACK = 4,
  parameter int CW   = 3
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               wr_en,
  input  logic [CW-1:0]      wr_idx,
  input  logic [WL-1:0]      wr_data,
  input  logic               clr,
  output logic [PACK*WL-1:0] lanes
);

  logic [PACK-1:0][WL-1:0] lane_q;

  // Capture the incoming word into its lane; a clear wins and zero-fills all lanes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lane_q <= '0;
    end else if (clr) begin
      lane_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < PACK; i++) begin
        if (wr_idx == CW'(i)) lane_q[i] <= wr_data;
      end
    end
  end

  assign lanes = lane_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Drains WL-bit words from a synchronous FIFO (1-cycle registered read data)
// and packs PACK words into one beat on a valid/ready output.
// Optional macro PACK_TIMEOUT_EN: flush a partial beat after TIMEOUT idle cycles.
module fifo_word_packer import fifo_pkg::*; #(
  parameter int WL      = WL_DEF,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_rq,
  input  logic [WL-1:0]            fifo_data,
  output logic [PACK*WL-1:0]       out_data,
  output logic [cnt_w(PACK)-1:0]   out_words,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int            CW      = cnt_w(PACK);
  localparam logic [CW-1:0] PACK_C  = CW'(PACK);
  localparam logic [CW-1:0] LAST_C  = CW'(PACK - 1);

  // Parameter sanity, caught at elaboration.
  if (PACK < 2 || PACK > 16) begin : g_bad_pack
    $error("fifo_word_packer: PACK out of range 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fifo_word_packer: TIMEOUT out of range 1..255");
  end

  pack_state_e   state;
  logic [CW-1:0] issued;
  logic [CW-1:0] captured;
  logic          rd_pending;
  logic          handshake;
  logic          done_full;
  logic          flush;

  // Reads stop once PACK are outstanding or captured; the FIFO empty flag
  // already accounts for the previous read, so back-to-back requests are safe.
  // Gating with n_rst keeps the request low while reset is held.
  assign fifo_rd_rq = n_rst & (state == FILL) & ~fifo_empty & (issued < PACK_C);
  assign handshake  = out_valid & out_ready;
  assign done_full  = rd_pending & (captured == LAST_C);

`ifdef PACK_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       idle;

  // Idle means: partial beat, nothing in flight and nothing to read.
  assign idle  = (state == FILL) & (captured != '0) & (captured < PACK_C)
               & fifo_empty & ~rd_pending;
  assign flush = idle & (({1'b0, idle_cnt} + 9'd1) >= 9'(TIMEOUT));

  // Count idle cycles of a partial beat; any read or leaving FILL restarts it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                          idle_cnt <= '0;
    else if (fifo_rd_rq || state != FILL) idle_cnt <= '0;
    else if (idle)                       idle_cnt <= idle_cnt + 8'd1;
  end
`else
  assign flush = 1'b0;
`endif

  // Packer FSM: issue/capture counters, beat presentation and handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= FILL;
      issued     <= '0;
      captured   <= '0;
      rd_pending <= 1'b0;
      out_valid  <= 1'b0;
      out_words  <= '0;
    end else begin
      rd_pending <= fifo_rd_rq;
      case (state)
        FILL: begin
          if (fifo_rd_rq) issued   <= issued + 1'b1;
          if (rd_pending) captured <= captured + 1'b1;
          // Go valid on the same edge as the last capture to save a cycle.
          if (done_full) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_words <= PACK_C;
          end else if (flush) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_words <= captured;
          end
        end
        HOLD: begin
          if (handshake) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_words <= '0;
            issued    <= '0;
            captured  <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Lanes are written only in FILL, so out_data is frozen while the beat is held.
  fifo_pack_lanes #(
    .WL   (WL),
    .PACK (PACK),
    .CW   (CW)
  ) u_lanes (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (rd_pending),
    .wr_idx  (captured),
    .wr_data (fifo_data),
    .clr     (handshake),
    .lanes   (out_data)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: a small FIFO model feeds the DUT,
// a word scoreboard predicts each beat in write order.
module tb_fifo_word_packer;

  localparam int WL      = 5;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(PACK + 1);

  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic                fifo_empty;
  logic                fifo_rd_rq;
  logic [WL-1:0]       fifo_data = '0;
  logic [PACK*WL-1:0]  out_data;
  logic [CW-1:0]       out_words;
  logic                out_valid;
  logic                out_ready = 1'b0;

  logic                wr_en = 1'b0;
  logic [WL-1:0]       wr_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_word_packer #(.WL(WL), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_rq (fifo_rd_rq),
    .fifo_data  (fifo_data),
    .out_data   (out_data),
    .out_words  (out_words),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Synchronous FIFO model: registered pointers, 1-cycle registered read data.
  logic [WL-1:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wp % 64] <= wr_data;
      wp <= wp + 1;
    end
    if (fifo_rd_rq && (wp != rp)) begin
      fifo_data <= mem[rp % 64];
      rp <= rp + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [WL-1:0]      exp_q [$];
  int                 exp_words = PACK;
  int                 cyc = 0;
  int                 beats = 0;
  int                 rd_cnt = 0;
  int                 rd_since = 0;
  int                 t_first = 0;
  int                 lat = 0;
  logic               hold_prev = 1'b0;
  logic               prev_valid = 1'b0;
  logic [PACK*WL-1:0] held_data = '0;
  logic [CW-1:0]      held_words = '0;
  logic [PACK*WL-1:0] exp_beat;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample on the falling edge: protocol rules, hold stability, beat contents.
  always @(negedge clk) begin
    if (!n_rst) begin
      rd_since   = 0;
      hold_prev  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (fifo_rd_rq) begin
        check("rd_when_empty", fifo_empty, 0);
        if (rd_since == 0) t_first = cyc;
        rd_since++;
        rd_cnt++;
      end
      if (out_valid) check("rd_in_hold", fifo_rd_rq, 0);
      if (out_valid && !prev_valid) lat = cyc - t_first;
      if (out_valid && hold_prev) begin
        check("hold_data", out_data, held_data);
        check("hold_words", out_words, held_words);
      end
      if (out_valid && out_ready) begin
        exp_beat = '0;
        if (exp_q.size() < exp_words) begin
          check("sb_underflow", exp_q.size(), exp_words);
        end else begin
          for (int i = 0; i < exp_words; i++) exp_beat[i*WL +: WL] = exp_q.pop_front();
        end
        check("beat_data", out_data, exp_beat);
        check("beat_words", out_words, exp_words);
        beats++;
        rd_since = 0;
      end
      hold_prev  = out_valid && !out_ready;
      held_data  = out_data;
      held_words = out_words;
      prev_valid = out_valid;
    end
  end

  // Write one word into the FIFO model (called on a falling edge).
  task automatic wr(input logic [WL-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget && beats < target; i++) @(negedge clk);
    check("beat_wait", beats >= target, 1);
  endtask

  int b0, r0, r1;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data, 0);
    check("rst_words", out_words, 0);
    check("rst_rd_rq", fifo_rd_rq, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // 1: single full beat, latency and read count
    out_ready = 1'b1;
    b0 = beats; r0 = rd_cnt;
    wr(5'h01); wr(5'h02); wr(5'h03); wr(5'h04);
    wait_beats(b0 + 1, 40);
    @(negedge clk);
    check("t1_rd_pulses", rd_cnt - r0, 4);
    check("t1_latency", lat, PACK + 1);
    check("t1_valid_1cyc", out_valid, 0);

    // 2: backpressure for 10 cycles, second beat afterwards
    out_ready = 1'b0;
    b0 = beats;
    for (int w = 5; w <= 12; w++) wr(WL'(w));
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    check("t2_valid", out_valid, 1);
    r1 = rd_cnt;
    repeat (10) @(negedge clk);
    check("t2_no_rd_hold", rd_cnt - r1, 0);
    check("t2_still_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_beats(b0 + 2, 60);

    // 3: FIFO empty mid-fill, no flush without the timeout feature
    b0 = beats; r0 = rd_cnt;
    wr(5'h0d); wr(5'h0e);
    repeat (20) @(negedge clk);
    check("t3_no_valid", out_valid, 0);
    check("t3_rd_2", rd_cnt - r0, 2);
    wr(5'h0f); wr(5'h10);
    wait_beats(b0 + 1, 40);

`ifdef PACK_TIMEOUT_EN
    // 4: partial beat flushed after TIMEOUT idle cycles
    b0 = beats;
    exp_words = 3;
    wr(5'h1a); wr(5'h1b); wr(5'h1c);
    wait_beats(b0 + 1, TIMEOUT + 20);
    @(negedge clk);
    exp_words = PACK;
`endif

    // 5: asynchronous reset after two captures
    wr(5'h11); wr(5'h12);
    repeat (4) @(negedge clk);
    check("t5_rd_before_rst", rd_since, 2);
    n_rst = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data",  out_data, 0);
    check("t5_rst_words", out_words, 0);
    check("t5_rst_rd_rq", fifo_rd_rq, 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge clk);
    n_rst = 1'b1;
    b0 = beats;
    wr(5'h13); wr(5'h14); wr(5'h15); wr(5'h16);
    wait_beats(b0 + 1, 40);

    // 6: trickle writer, one word every two cycles
    b0 = beats;
    for (int w = 0; w < 8; w++) begin
      wr(WL'(5'h17 + w));
      @(negedge clk);
    end
    wait_beats(b0 + 2, 80);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the synchronous FIFO. Drains WL-bit words from the FIFO read port using its empty flag and its 1-cycle registered read data. Packs PACK consecutive words into one wide output beat. Presents the beat on a valid/ready interface to the next stage, typically a bus master or serializer.

Parameters:
WL, 5, FIFO word width in bits; must match the FIFO instance.
PACK, 4, words per output beat; legal range 2..16.
TIMEOUT, 16, idle cycles before a partial beat is flushed (used only with PACK_TIMEOUT_EN); legal range 1..255.

Ports:
clk  input  1  clock, rising edge.
n_rst  input  1  reset, asynchronous, active-low.
fifo_empty  input  1  FIFO empty flag; registered-state based, current every cycle.
fifo_rd_rq  output  1  read request to the FIFO.
fifo_data  input  WL  FIFO read data; valid the cycle after an accepted read request.
out_data  output  PACK*WL  packed beat; word 0 (oldest) in bits [WL-1:0].
out_words  output  $clog2(PACK+1)  number of valid words in out_data.
out_valid  output  1  beat valid.
out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, n_rst=0): state=FILL, fifo_rd_rq=0, out_valid=0, out_data=0, out_words=0. Internal issue count, capture count, rd_pending and timeout counter all clear.
- fifo_rd_rq is combinational: (state==FILL) & ~fifo_empty & (issued < PACK).
- A read is counted as issued only when fifo_rd_rq=1. rd_pending is set on the next edge.
- The cycle after rd_pending=1, fifo_data is captured into lane[captured] and captured increments.
- Back-to-back reads are allowed. The FIFO flags reflect the previous read, so no over-read is possible.
- FSM states:
  - FILL: issue reads until issued==PACK. When captured reaches PACK, move to HOLD.
  - HOLD: out_valid=1, out_data and out_words=PACK are stable. No reads are issued. On out_valid & out_ready, clear issued/captured/lanes and return to FILL. The next read may issue in the cycle after the handshake.
- out_data, out_words and out_valid are registered and must not change while out_valid=1 and out_ready=0.
- Latency: first read request to out_valid = PACK+1 cycles when the FIFO is never empty. Sustained throughput is 1 beat per PACK+2 cycles with out_ready tied high.
- FIFO empty mid-fill: stall in FILL with issued and lanes held. Resume when fifo_empty=0. No timeout without the macro.
- out_ready asserted while out_valid=0: ignored.
- Count arithmetic: issued and captured use $clog2(PACK+1) bits. They never exceed PACK and never wrap.
- Reset mid-beat: partial lanes are discarded. Any FIFO read already issued is lost, which is accepted.
- Unused lanes in partial beats read as 0.

Optional Feature:
- Macro: PACK_TIMEOUT_EN.
- Defined:
  - Add an 8-bit idle counter, active in FILL while 0 < captured < PACK, fifo_empty=1 and rd_pending=0.
  - It clears whenever a read is issued.
  - When it reaches TIMEOUT, move to HOLD with out_words=captured and the unused lanes zero.
- Not defined: no counter; out_words is always PACK in HOLD.

Decomposition:
- Shared package fifo_pkg:
  - WL default.
  - State enum {FILL, HOLD}.
  - Helper function for count width, $clog2(PACK+1).
- One natural sub-module: fifo_pack_lanes, the lane register array with a capture-index write, clear and zero-fill.
- FSM, counters and handshake stay in the top module.

Test Plan:
1. FIFO preloaded with 0x01,0x02,0x03,0x04, out_ready=1 → out_data=0x04_03_02_01 packed in 5-bit lanes (word 0 = bits [4:0]), out_words=4, out_valid high for 1 cycle, and exactly 4 fifo_rd_rq pulses.
2. 8 words preloaded, out_ready held 0 for 10 cycles after the first out_valid → out_data stable, no fifo_rd_rq during the hold. After release, second beat = words 5..8.
3. 2 words written, 20-cycle gap, 2 more written → no reads while empty, single beat = words 1..4, out_words=4 (macro off).
4. With PACK_TIMEOUT_EN, TIMEOUT=16: 3 words then idle → out_valid after 16 idle cycles, out_words=3, upper lane 0.
5. Reset asserted after 2 captures → outputs zero immediately (asynchronous). After release, the next beat starts at lane 0 with the subsequent FIFO words.
6. FIFO at almost_empty (1 word) with a concurrent writer at 1 word/2 cycles → no fifo_rd_rq while fifo_empty=1, and every captured word matches the write order.
